// File: rtl/shiftreg_seq_ctrl_pkg.sv
// Shared definitions for the shift register datapath and its sequencer.
// Holds the register mode encodings and the sequencer state encoding.
package shiftreg_seq_ctrl_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shiftreg_seq_ctrl_step_counter.sv
// seq_step_counter: loadable down-counter for the remaining shift steps.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          clear count to zero (highest priority)
//   load         load load_val
//   load_val     value to load
//   dec          decrement enable; saturates at zero
//   count        current count
//   zero         count == 0
//   last         count == 1 (the next decrement is the final step)
module seq_step_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// shiftreg_seq_ctrl: sequencer driving the shift register datapath.
// On start it latches the configuration, issues one parallel-load step on
// the next accepted tick, then cfg_count shift/rotate steps, one per tick.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   tick                rate enable from the clock divider
//   start, abort        one-cycle control pulses
//   cfg_dir/rotate/count/data  sequence configuration, latched on start
//   q_fb                current shift register contents
//   sr_m, sr_d, sr_si   register mode, load data, serial-in bit
//   sr_step             one-cycle step enable for the register
//   busy, done          sequence active / one-cycle completion pulse
//   steps_left          remaining shift steps
module shiftreg_seq_ctrl
  import shiftreg_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_dir,
  input  logic             cfg_rotate,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [1:0]       sr_m,
  output logic [WIDTH-1:0] sr_d,
  output logic             sr_si,
  output logic             sr_step,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  state_t           state, state_nx;
  logic             dir_q, rot_q;
  logic [WIDTH-1:0] data_q;
  logic             fin_q, fin_nx;
  logic [1:0]       m_nx;
  logic [WIDTH-1:0] d_nx;
  logic             si_nx, step_nx, done_nx;
  logic             latch, cnt_load, cnt_dec, cnt_clr;
  logic             cnt_zero, cnt_last, acc;
  // Only the end bits of q_fb feed the rotate; the reduction keeps the
  // remaining bits visibly consumed.
  logic             unused_q_fb;

  assign unused_q_fb = ^q_fb;

  seq_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cfg_count),
    .dec      (cnt_dec),
    .count    (steps_left),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  assign busy = (state == LOAD) || (state == SHIFT);

  // Ticks coinciding with a step are dropped so q_fb has settled before
  // the next rotate bit is sampled.
  assign acc = tick && !sr_step &&
               ((state == LOAD) || ((state == SHIFT) && !cnt_zero));

  // The state leaves LOAD/SHIFT on the edge that ends the step cycle, using
  // fin_q (captured when the step was issued), so busy falls with done.
  always_comb begin
    state_nx = state;
    m_nx     = MODE_HOLD;
    d_nx     = sr_d;
    si_nx    = 1'b0;
    step_nx  = 1'b0;
    fin_nx   = fin_q;
    latch    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          latch    = 1'b1;
          cnt_load = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (sr_step) begin
          state_nx = fin_q ? DONE : SHIFT;
        end else if (acc) begin
          step_nx = 1'b1;
          m_nx    = MODE_LOAD;
          d_nx    = data_q;
          fin_nx  = cnt_zero;
        end
      end
      SHIFT: begin
        if (sr_step) begin
          if (fin_q) state_nx = DONE;
        end else if (acc) begin
          step_nx = 1'b1;
          m_nx    = dir_q ? MODE_SHL : MODE_SHR;
          si_nx   = rot_q && (dir_q ? q_fb[WIDTH-1] : q_fb[0]);
          cnt_dec = 1'b1;
          fin_nx  = cnt_last;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      m_nx     = MODE_HOLD;
      si_nx    = 1'b0;
      step_nx  = 1'b0;
      latch    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b1;
    end
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sr_m    <= MODE_HOLD;
      sr_d    <= '0;
      sr_si   <= 1'b0;
      sr_step <= 1'b0;
      done    <= 1'b0;
      fin_q   <= 1'b0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_nx;
      sr_m    <= m_nx;
      sr_d    <= d_nx;
      sr_si   <= si_nx;
      sr_step <= step_nx;
      done    <= done_nx;
      fin_q   <= fin_nx;
      if (latch) begin
        dir_q  <= cfg_dir;
        rot_q  <= cfg_rotate;
        data_q <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
module tb_shiftreg_seq_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick;
  logic         auto_tick = 1'b0, man_tick = 1'b0;
  logic         start = 1'b0, abort = 1'b0;
  logic         cfg_dir = 1'b0, cfg_rotate = 1'b0;
  logic [C-1:0] cfg_count = '0;
  logic [W-1:0] cfg_data = '0;
  logic [W-1:0] q_reg = '0;
  logic [1:0]   sr_m;
  logic [W-1:0] sr_d;
  logic         sr_si, sr_step, busy, done;
  logic [C-1:0] steps_left;

  int checks = 0;
  int errors = 0;
  int tick_period = 0;

  assign tick = auto_tick | man_tick;

  always #5 clk = ~clk;

  shiftreg_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
    .cfg_dir(cfg_dir), .cfg_rotate(cfg_rotate), .cfg_count(cfg_count),
    .cfg_data(cfg_data), .q_fb(q_reg), .sr_m(sr_m), .sr_d(sr_d),
    .sr_si(sr_si), .sr_step(sr_step), .busy(busy), .done(done),
    .steps_left(steps_left)
  );

  // Transaction-level model: a running job first owes one load, then a
  // number of shifts; each owed step is served by the next free tick.
  logic [1:0]   e_m = '0;
  logic [W-1:0] e_d = '0;
  logic         e_si = 1'b0, e_step = 1'b0, e_done = 1'b0;
  logic [C-1:0] e_left = '0;
  logic         active = 1'b0, loaded = 1'b0, m_final = 1'b0;
  logic [W-1:0] sh_data = '0;
  logic         sh_dir = 1'b0, sh_rot = 1'b0;

  always @(posedge clk) begin
    logic [1:0]   n_m;
    logic [W-1:0] n_d;
    logic         n_si, n_step, n_done;
    if (!rst) begin
      e_m = '0; e_d = '0; e_si = 0; e_step = 0; e_done = 0; e_left = '0;
      active = 0; loaded = 0; m_final = 0;
    end else begin
      n_m = 2'b00; n_d = e_d; n_si = 0; n_step = 0; n_done = 0;
      if (abort) begin
        active = 0;
        e_left = '0;
      end else if (active) begin
        if (e_step) begin
          if (m_final) begin
            active = 0;
            n_done = 1;
          end
        end else if (tick) begin
          n_step = 1;
          if (!loaded) begin
            n_m = 2'b11; n_d = sh_data; loaded = 1;
            m_final = (e_left == 0);
          end else begin
            n_m  = sh_dir ? 2'b10 : 2'b01;
            n_si = sh_rot && (sh_dir ? q_reg[W-1] : q_reg[0]);
            e_left = e_left - 1'b1;
            m_final = (e_left == 0);
          end
        end
      end else if (!e_done && start) begin
        sh_data = cfg_data; sh_dir = cfg_dir; sh_rot = cfg_rotate;
        e_left = cfg_count; active = 1; loaded = 0;
      end
      e_m = n_m; e_d = n_d; e_si = n_si; e_step = n_step; e_done = n_done;
    end
    // Shift register datapath (own reset, never asserted here).
    if (sr_step) begin
      case (sr_m)
        2'b01: q_reg <= {sr_si, q_reg[W-1:1]};
        2'b10: q_reg <= {q_reg[W-2:0], sr_si};
        2'b11: q_reg <= sr_d;
        default: q_reg <= q_reg;
      endcase
    end
  end

  initial begin
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      auto_tick = (tick_period != 0) && (cyc % tick_period == 0);
    end
  end

  int           n_loads = 0, n_shifts = 0, n_done = 0;
  logic [W-1:0] last_d = '0;
  logic [15:0]  si_log = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if ({sr_m, sr_d, sr_si, sr_step, busy, done, steps_left} !==
            {e_m, e_d, e_si, e_step, active, e_done, e_left}) begin
          errors++;
          $display("FAIL cycle t=%0t got m=%b d=%b si=%b step=%b busy=%b done=%b left=%0d expected m=%b d=%b si=%b step=%b busy=%b done=%b left=%0d",
                   $time, sr_m, sr_d, sr_si, sr_step, busy, done, steps_left,
                   e_m, e_d, e_si, e_step, active, e_done, e_left);
        end
        if (sr_step && sr_m == 2'b11) begin n_loads++; last_d = sr_d; end
        if (sr_step && (sr_m == 2'b01 || sr_m == 2'b10)) begin
          n_shifts++; si_log = {si_log[14:0], sr_si};
        end
        if (done) n_done++;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge with cfg scrambled.
  task automatic start_seq(input logic [W-1:0] d, input logic dir, input logic rot,
                           input logic [C-1:0] cnt);
    cfg_data = d; cfg_dir = dir; cfg_rotate = rot; cfg_count = cnt; start = 1;
    @(negedge clk);
    start = 0;
    cfg_data = ~d; cfg_dir = ~dir; cfg_rotate = ~rot; cfg_count = cnt + 4'd3;
    chk("latched_steps_left", steps_left, cnt);
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1);
    chk({name, "_busy"}, busy, 0);
    @(negedge clk);
  endtask

  task automatic do_tick();
    man_tick = 1;
    @(negedge clk);
    man_tick = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, s0, d0;
    logic [7:0] pat;
    fork cmp_loop(); join_none

    repeat (2) @(negedge clk);
    chk("rst_m", sr_m, 0);
    chk("rst_step", sr_step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", steps_left, 0);
    #2 rst = 1;
    @(negedge clk);

    // Basic logical shift right
    l0 = n_loads; s0 = n_shifts; d0 = n_done;
    tick_period = 5;
    start_seq(4'b1001, 0, 0, 4'd2);
    wait_done("basic_done", 100);
    tick_period = 0;
    chk("basic_loads", n_loads - l0, 1);
    chk("basic_load_d", last_d, 4'b1001);
    chk("basic_shifts", n_shifts - s0, 2);
    chk("basic_si", si_log[1:0], 2'b00);
    chk("basic_q", q_reg, 4'b0010);
    chk("basic_dones", n_done - d0, 1);

    // Rotate left
    s0 = n_shifts;
    tick_period = 4;
    start_seq(4'b1000, 1, 1, 4'd4);
    wait_done("rotl_done", 100);
    tick_period = 0;
    chk("rotl_shifts", n_shifts - s0, 4);
    chk("rotl_si_seq", si_log[3:0], 4'b1000);
    chk("rotl_q", q_reg, 4'b1000);

    // Zero count: load only
    l0 = n_loads; s0 = n_shifts; d0 = n_done;
    tick_period = 3;
    start_seq(4'b0110, 0, 0, 4'd0);
    wait_done("zero_done", 50);
    tick_period = 0;
    chk("zero_loads", n_loads - l0, 1);
    chk("zero_shifts", n_shifts - s0, 0);
    chk("zero_dones", n_done - d0, 1);
    chk("zero_q", q_reg, 4'b0110);

    // Maximum count: 15 rotates right
    s0 = n_shifts;
    tick_period = 3;
    start_seq(4'b0001, 0, 1, 4'd15);
    wait_done("max_done", 200);
    tick_period = 0;
    chk("max_shifts", n_shifts - s0, 15);
    chk("max_q", q_reg, 4'b0010);

    // Back-to-back ticks: tick held high for the whole run
    start_seq(4'b0110, 0, 1, 4'd3);
    man_tick = 1;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], sr_step};
      @(negedge clk);
    end
    chk("b2b_done", done, 1);
    man_tick = 0;
    chk("b2b_step_pattern", pat, 8'h55);
    @(negedge clk);
    chk("b2b_q", q_reg, 4'b1100);
    chk("b2b_si", si_log[2:0], 3'b011);

    // Abort mid-shift with a coincident tick
    s0 = n_shifts; d0 = n_done;
    start_seq(4'b1111, 0, 0, 4'd5);
    do_tick(); do_tick(); do_tick();
    chk("abort_left_before", steps_left, 3);
    man_tick = 1; abort = 1;
    @(negedge clk);
    man_tick = 0; abort = 0;
    chk("abort_step", sr_step, 0);
    chk("abort_busy", busy, 0);
    chk("abort_left", steps_left, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_shifts", n_shifts - s0, 2);
    chk("abort_q", q_reg, 4'b0011);
    tick_period = 4;
    start_seq(4'b0101, 1, 0, 4'd1);
    wait_done("after_abort_done", 60);
    tick_period = 0;
    chk("after_abort_q", q_reg, 4'b1010);

    // start and abort together in IDLE
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);
    @(negedge clk);
    chk("start_abort_busy2", busy, 0);

    // Ignored start during SHIFT, then asynchronous reset mid-step
    start_seq(4'b1010, 1, 1, 4'd6);
    do_tick(); do_tick();
    chk("ign_left_before", steps_left, 5);
    chk("ign_q_before", q_reg, 4'b0101);
    cfg_count = 4'd2; start = 1;
    @(negedge clk);
    start = 0;
    chk("ign_left", steps_left, 5);
    chk("ign_busy", busy, 1);
    man_tick = 1;
    @(negedge clk);
    man_tick = 0;
    chk("pre_rst_step", sr_step, 1);
    #2 rst = 0;
    #1;
    chk("arst_m", sr_m, 0);
    chk("arst_d", sr_d, 0);
    chk("arst_si", sr_si, 0);
    chk("arst_step", sr_step, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_left", steps_left, 0);
    @(negedge clk);
    #2 rst = 1;
    chk("arst_q_kept", q_reg, 4'b0101);
    @(negedge clk);

    // Normal operation after reset
    tick_period = 3;
    start_seq(4'b0011, 0, 0, 4'd1);
    wait_done("post_rst_done", 60);
    tick_period = 0;
    chk("post_rst_q", q_reg, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shiftreg_seq_ctrl.md
Name: shiftreg_seq_ctrl

Overview:
Sequencer that drives the 4-bit shift register datapath automatically, replacing manual mode switches and step presses. On a start pulse it parallel-loads a configured pattern, then issues a programmed number of shift or rotate steps, one per rate tick from the clock divider. It sits between the one-shot/switch inputs and the shift register, and owns the register's mode, data and step-enable inputs.

Parameters:
WIDTH, 4, shift register width in bits.
CNT_W, 4, width of the step-count field; maximum is 2^CNT_W-1 steps.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
tick  input  1  one-cycle rate enable from the clock divider.
start  input  1  one-cycle start pulse from the one-shot.
abort  input  1  one-cycle abort pulse.
cfg_dir  input  1  0 = shift right (toward bit 0), 1 = shift left.
cfg_rotate  input  1  1 = rotate; 0 = logical shift with zero fill.
cfg_count  input  CNT_W  number of shift steps after the load.
cfg_data  input  WIDTH  pattern to load.
q_fb  input  WIDTH  current shift register contents.
sr_m  output  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 load.
sr_d  output  WIDTH  parallel load data.
sr_si  output  1  serial input bit.
sr_step  output  1  one-cycle step enable; the register acts on the clk edge where sr_step=1.
busy  output  1  high in LOAD and SHIFT.
done  output  1  one-cycle completion pulse.
steps_left  output  CNT_W  remaining shift steps.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, sr_m=00, sr_d=0, sr_si=0, sr_step=0, busy=0, done=0, steps_left=0, shadow config cleared.
- All outputs are registered. busy is decoded from the registered state.
- States are IDLE, LOAD, SHIFT and DONE.
- IDLE:
  - sr_m=00, sr_step=0.
  - On start=1 and abort=0: latch cfg_dir, cfg_rotate, cfg_count and cfg_data into shadow registers; steps_left<=cfg_count; go to LOAD.
  - cfg_* changes after this latch have no effect until the next start.
- LOAD:
  - Waits for an accepted tick.
  - On that tick, in the next cycle: sr_m=11, sr_d=shadow data, sr_step=1.
  - Then: if steps_left==0 go to DONE, else go to SHIFT.
- SHIFT, on each accepted tick, in the next cycle:
  - sr_step=1.
  - sr_m=01 if dir=0, 10 if dir=1.
  - sr_si: if rotate=0, sr_si=0. If rotate=1 and dir=0, sr_si=q_fb[0]. If rotate=1 and dir=1, sr_si=q_fb[WIDTH-1].
  - steps_left decrements.
  - When the step that takes steps_left from 1 to 0 issues, go to DONE.
- DONE: done=1 for exactly one cycle, sr_m=00, then go to IDLE.
- Latency:
  - A tick sampled at edge k produces sr_step high during cycle k+1, with sr_m, sr_d and sr_si valid in that same cycle.
  - Start to the load step is at least 2 cycles (start edge, then tick edge).
- Tick acceptance:
  - A tick in a cycle where sr_step=1 is dropped. This guarantees q_fb reflects the previous step before sr_si is computed for a rotate.
  - Ticks in IDLE and DONE are ignored.
- sr_m returns to 00 in every cycle where sr_step=0.
- A start while busy or in DONE is ignored; it is neither queued nor used to re-latch config.
- Abort:
  - abort=1 in any state goes to IDLE on the next edge.
  - No sr_step is issued for a tick in the same cycle as abort; abort has priority over tick.
  - steps_left is cleared to 0 and done is not pulsed.
  - start and abort together in IDLE: abort wins and the state stays IDLE.
- cfg_count=0: load only, then DONE.
- cfg_count=max: 2^CNT_W-1 shifts. The counter never wraps; it saturates at 0.
- Reset asserted mid-sequence: outputs are immediately at reset values. The datapath keeps its partially shifted contents, since it has its own reset.

Decomposition:
- Shared package: mode encodings (MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11) and the state encoding (IDLE, LOAD, SHIFT, DONE). The existing shift register and this block both reference the package.
- One natural sub-module: seq_step_counter. It is a loadable CNT_W down-counter with a load input, a decrement enable, clear, a zero flag and a last-step flag.
- The FSM and the sr_si mux stay in shiftreg_seq_ctrl.

Test Plan:
- Basic shift: cfg_data=4'b1001, dir=0, rotate=0, count=2, start, ticks every 5 cycles.
  -> One load step with sr_d=1001, then 2 steps with sr_m=01 and sr_si=0; a register model ends at 0010; done pulses once; busy falls with done.
- Rotate left: data=4'b1000, dir=1, rotate=1, count=4.
  -> sr_si sequence is 1,0,0,0; the register model returns to 1000 after 4 steps.
- Zero count: count=0, start, tick.
  -> Exactly one sr_step with sr_m=11, then a done pulse; no shift steps.
- Back-to-back ticks: tick held high for 6 cycles in SHIFT.
  -> sr_step toggles 1,0,1,0; every tick coincident with sr_step=1 is dropped; steps_left decrements once per step.
- Abort mid-shift: count=5, abort after step 2, with tick in the same cycle.
  -> No sr_step that cycle; next state IDLE; steps_left=0; no done pulse; a following start with new cfg runs normally.
- Reset and ignored start: start pulsed during SHIFT, then rst=0 asserted asynchronously mid-cycle.
  -> The extra start does not change steps_left; on reset all outputs go to 0 immediately, before the next clk edge.
